wb_stage: RTL and testbench

- Writeback/retire stage, directly downstream of the memory stage.
- Consumes the registered memory-stage pipeline bus and commits results into the architectural register file.
- Serves the decode stage's two read ports with same-cycle write-through.
- Drives the WB bypass bus to execute, and maintains the 64-bit cycle and instret counters, readable/writable via a CSR side port.

---
 rtl/core_pkg.sv | 46 ++++
 rtl/regfile_2r1w.sv | 47 ++++
 rtl/wb_stage.sv | 115 +++++++++++
 tb/tb_wb_stage.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: pipeline/bypass buses, counter word selects and the split-counter update.
package core;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned NUM_REGS     = 32;
   localparam int unsigned REG_IDX_BITS = $clog2(NUM_REGS);
   localparam int unsigned CNT_WIDTH    = 64;

   typedef enum logic [1:0] {
      CNT_CYCLE_LO   = 2'd0,
      CNT_CYCLE_HI   = 2'd1,
      CNT_INSTRET_LO = 2'd2,
      CNT_INSTRET_HI = 2'd3
   } csr_cnt_sel_t;

   typedef struct packed {
      logic                    valid;
      logic                    rd_wen;
      logic [REG_IDX_BITS-1:0] rd;
      logic [XLEN-1:0]         result;
      logic [XLEN-1:0]         pc;
      logic [31:0]             instr;
   } pipeline_bus_t;

   typedef struct packed {
      logic                    valid;
      logic [REG_IDX_BITS-1:0] rd;
      logic [XLEN-1:0]         data;
   } bypass_bus_t;

   // A written word takes wdata exactly, but the high word always absorbs the low-word carry.
   function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic                 inc,
                                                     input logic                 we_lo,
                                                     input logic                 we_hi,
                                                     input logic [XLEN-1:0]      wdata);
      logic [XLEN:0]   lo_sum;
      logic [XLEN-1:0] lo;
      logic [XLEN-1:0] hi;
      lo_sum = {1'b0, cnt[XLEN-1:0]} + {{XLEN{1'b0}}, inc};
      lo     = we_lo ? wdata : lo_sum[XLEN-1:0];
      hi     = (we_hi ? wdata : cnt[CNT_WIDTH-1:XLEN]) + {{(XLEN-1){1'b0}}, lo_sum[XLEN]};
      return {hi, lo};
   endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports with write-through, one write port,
// x0 hardwired to zero, synchronous active-low clear.
module regfile_2r1w
   import core::*;
#(
   parameter int unsigned NUM_REGS = core::NUM_REGS,
   parameter int unsigned XLEN     = core::XLEN
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we,
   input  logic [REG_IDX_BITS-1:0] waddr,
   input  logic [XLEN-1:0]         wdata,
   input  logic [REG_IDX_BITS-1:0] raddr1,
   input  logic [REG_IDX_BITS-1:0] raddr2,
   output logic [XLEN-1:0]         rdata1,
   output logic [XLEN-1:0]         rdata2
);

   logic [XLEN-1:0] mem_q [NUM_REGS];
   logic            wr_en;

   assign wr_en = we && (waddr != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = mem_q[raddr1];
      if (wr_en && (raddr1 == waddr)) rdata1 = wdata;
      if (raddr1 == '0) rdata1 = '0;
   end

   always_comb begin
      rdata2 = mem_q[raddr2];
      if (wr_en && (raddr2 == waddr)) rdata2 = wdata;
      if (raddr2 == '0) rdata2 = '0;
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback/retire stage: regfile commit, WB bypass, cycle/instret counters with CSR port.
// Optional retirement trace outputs are built when WB_TRACE_EN is defined.
module wb_stage
   import core::*;
#(
   parameter int unsigned XLEN      = core::XLEN,
   parameter int unsigned NUM_REGS  = core::NUM_REGS,
   parameter int unsigned CNT_WIDTH = core::CNT_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  pipeline_bus_t           bus_i,
   input  logic [REG_IDX_BITS-1:0] rs1_addr_i,
   input  logic [REG_IDX_BITS-1:0] rs2_addr_i,
   output logic [XLEN-1:0]         rs1_data_o,
   output logic [XLEN-1:0]         rs2_data_o,
   output bypass_bus_t             wb_bp_o,
   input  logic                    csr_we_i,
   input  logic [1:0]              csr_sel_i,
   input  logic [XLEN-1:0]         csr_wdata_i,
   output logic [XLEN-1:0]         csr_rdata_o,
   output logic                    retire_o
`ifdef WB_TRACE_EN
   ,
   output logic                    trace_valid_o,
   output logic [31:0]             trace_pc_o,
   output logic [31:0]             trace_instr_o,
   output logic [4:0]              trace_rd_o,
   output logic [31:0]             trace_wdata_o
`endif
);

   logic                 commit;
   csr_cnt_sel_t         sel;
   logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
   logic [CNT_WIDTH-1:0] instret_q, instret_d;

   assign commit   = bus_i.valid && bus_i.rd_wen && (bus_i.rd != '0);
   assign sel      = csr_cnt_sel_t'(csr_sel_i);
   assign retire_o = bus_i.valid;

   assign wb_bp_o.valid = commit;
   assign wb_bp_o.rd    = bus_i.rd;
   assign wb_bp_o.data  = bus_i.result;

   regfile_2r1w #(
      .NUM_REGS (NUM_REGS),
      .XLEN     (XLEN)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .we     (commit),
      .waddr  (bus_i.rd),
      .wdata  (bus_i.result),
      .raddr1 (rs1_addr_i),
      .raddr2 (rs2_addr_i),
      .rdata1 (rs1_data_o),
      .rdata2 (rs2_data_o)
   );

   always_comb begin
      cycle_d   = cnt_next(cycle_q, 1'b1,
                           csr_we_i && (sel == CNT_CYCLE_LO),
                           csr_we_i && (sel == CNT_CYCLE_HI), csr_wdata_i);
      instret_d = cnt_next(instret_q, bus_i.valid,
                           csr_we_i && (sel == CNT_INSTRET_LO),
                           csr_we_i && (sel == CNT_INSTRET_HI), csr_wdata_i);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      csr_rdata_o = '0;
      unique case (sel)
         CNT_CYCLE_LO:   csr_rdata_o = cycle_q[XLEN-1:0];
         CNT_CYCLE_HI:   csr_rdata_o = cycle_q[CNT_WIDTH-1:XLEN];
         CNT_INSTRET_LO: csr_rdata_o = instret_q[XLEN-1:0];
         CNT_INSTRET_HI: csr_rdata_o = instret_q[CNT_WIDTH-1:XLEN];
         default:        csr_rdata_o = '0;
      endcase
   end

`ifdef WB_TRACE_EN
   // Payload holds the last retired instruction; only the valid flag follows bubbles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         trace_valid_o <= 1'b0;
         trace_pc_o    <= '0;
         trace_instr_o <= '0;
         trace_rd_o    <= '0;
         trace_wdata_o <= '0;
      end else begin
         trace_valid_o <= bus_i.valid;
         if (bus_i.valid) begin
            trace_pc_o    <= bus_i.pc;
            trace_instr_o <= bus_i.instr;
            trace_rd_o    <= bus_i.rd;
            trace_wdata_o <= bus_i.result;
         end
      end
   end
`else
   logic unused_trace;
   assign unused_trace = ^{bus_i.pc, bus_i.instr};
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage; trace checks are compiled when WB_TRACE_EN is defined.
module tb_wb_stage;
   import core::*;

   logic          clk = 1'b0;
   logic          rst;
   pipeline_bus_t bus;
   logic [4:0]    rs1_addr, rs2_addr;
   logic [31:0]   rs1_data, rs2_data;
   bypass_bus_t   wb_bp;
   logic          csr_we;
   logic [1:0]    csr_sel;
   logic [31:0]   csr_wdata, csr_rdata;
   logic          retire;
`ifdef WB_TRACE_EN
   logic          trace_valid;
   logic [31:0]   trace_pc, trace_instr, trace_wdata;
   logic [4:0]    trace_rd;
`endif

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [31:0]   sb[$];
   logic [31:0]   exp_v;

   wb_stage dut (
      .clk         (clk),
      .rst         (rst),
      .bus_i       (bus),
      .rs1_addr_i  (rs1_addr),
      .rs2_addr_i  (rs2_addr),
      .rs1_data_o  (rs1_data),
      .rs2_data_o  (rs2_data),
      .wb_bp_o     (wb_bp),
      .csr_we_i    (csr_we),
      .csr_sel_i   (csr_sel),
      .csr_wdata_i (csr_wdata),
      .csr_rdata_o (csr_rdata),
      .retire_o    (retire)
`ifdef WB_TRACE_EN
      ,
      .trace_valid_o (trace_valid),
      .trace_pc_o    (trace_pc),
      .trace_instr_o (trace_instr),
      .trace_rd_o    (trace_rd),
      .trace_wdata_o (trace_wdata)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst    = 1'b0;
      bus    = '0;
      csr_we = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic set_commit(input logic [4:0] rd, input logic wen, input logic [31:0] data);
      bus        = '0;
      bus.valid  = 1'b1;
      bus.rd_wen = wen;
      bus.rd     = rd;
      bus.result = data;
   endtask

   task automatic test_reset();
      do_reset();
      for (int s = 0; s < 4; s++) begin
         csr_sel = 2'(s);
         sb.push_back(32'h0);
         #1;
         exp_v = sb.pop_front();
         n_checks++;
         if (csr_rdata !== exp_v) begin
            $display("FAIL reset_csr sel=%0d got %h expected %h", s, csr_rdata, exp_v);
            n_fail++;
         end
      end
      sb.push_back(32'h0);
      sb.push_back(32'h0);
      #1;
      exp_v = sb.pop_front();
      n_checks++;
      if ({31'd0, retire} !== exp_v) begin
         $display("FAIL reset_retire got %b expected %h", retire, exp_v);
         n_fail++;
      end
      exp_v = sb.pop_front();
      n_checks++;
      if ({31'd0, wb_bp.valid} !== exp_v) begin
         $display("FAIL reset_bp_valid got %b expected %h", wb_bp.valid, exp_v);
         n_fail++;
      end
      for (int a = 0; a < 32; a++) begin
         rs1_addr = 5'(a);
         rs2_addr = 5'(31 - a);
         sb.push_back(32'h0);
         sb.push_back(32'h0);
         #1;
         exp_v = sb.pop_front();
         n_checks++;
         if (rs1_data !== exp_v) begin
            $display("FAIL reset_rs1 x%0d got %h expected %h", a, rs1_data, exp_v);
            n_fail++;
         end
         exp_v = sb.pop_front();
         n_checks++;
         if (rs2_data !== exp_v) begin
            $display("FAIL reset_rs2 x%0d got %h expected %h", 31 - a, rs2_data, exp_v);
            n_fail++;
         end
      end
   endtask

   task automatic test_commit_bypass();
      set_commit(5'd5, 1'b1, 32'hDEAD_BEEF);
      rs1_addr = 5'd5;
      rs2_addr = 5'd5;
      sb.push_back(32'hDEAD_BEEF);
      sb.push_back(32'hDEAD_BEEF);
      sb.push_back({1'b1, 5'd5, 26'd0});
      sb.push_back(32'hDEAD_BEEF);
      #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (rs1_data !== exp_v) begin
         $display("FAIL wt_rs1 got %h expected %h", rs1_data, exp_v);
         n_fail++;
      end
      exp_v = sb.pop_front();
      n_checks++;
      if (rs2_data !== exp_v) begin
         $display("FAIL wt_rs2 got %h expected %h", rs2_data, exp_v);
         n_fail++;
      end
      exp_v = sb.pop_front();
      n_checks++;
      if ({wb_bp.valid, wb_bp.rd, 26'd0} !== exp_v || retire !== 1'b1) begin
         $display("FAIL bp_ctrl got valid=%b rd=%0d retire=%b expected %h/1",
                  wb_bp.valid, wb_bp.rd, retire, exp_v);
         n_fail++;
      end
      exp_v = sb.pop_front();
      n_checks++;
      if (wb_bp.data !== exp_v) begin
         $display("FAIL bp_data got %h expected %h", wb_bp.data, exp_v);
         n_fail++;
      end
      tick();
      bus = '0;
      sb.push_back(32'hDEAD_BEEF);
      #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (rs1_data !== exp_v) begin
         $display("FAIL stored_rs1 got %h expected %h", rs1_data, exp_v);
         n_fail++;
      end
      // Write to x7 must not leak into a read of x5
      set_commit(5'd7, 1'b1, 32'h0BAD_F00D);
      rs1_addr = 5'd7;
      rs2_addr = 5'd5;
      sb.push_back(32'h0BAD_F00D);
      sb.push_back(32'hDEAD_BEEF);
      #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (rs1_data !== exp_v) begin
         $display("FAIL wt_x7_rs1 got %h expected %h", rs1_data, exp_v);
         n_fail++;
      end
      exp_v = sb.pop_front();
      n_checks++;
      if (rs2_data !== exp_v) begin
         $display("FAIL nohit_rs2 got %h expected %h", rs2_data, exp_v);
         n_fail++;
      end
      tick();
      bus = '0;
      rs2_addr = 5'd7;
      sb.push_back(32'h0BAD_F00D);
      #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (rs2_data !== exp_v) begin
         $display("FAIL stored_x7 got %h expected %h", rs2_data, exp_v);
         n_fail++;
      end
   endtask

   task automatic test_x0();
      do_reset();
      set_commit(5'd0, 1'b1, 32'h0000_1234);
      rs1_addr = 5'd0;
      rs2_addr = 5'd0;
      sb.push_back(32'h0);
      sb.push_back(32'h0);
      sb.push_back(32'h1);
      #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (rs1_data !== exp_v || rs2_data !== exp_v) begin
         $display("FAIL x0_read got %h/%h expected %h", rs1_data, rs2_data, exp_v);
         n_fail++;
      end
      exp_v = sb.pop_front();
      n_checks++;
      if ({31'd0, wb_bp.valid} !== exp_v) begin
         $display("FAIL x0_bp_valid got %b expected %h", wb_bp.valid, exp_v);
         n_fail++;
      end
      exp_v = sb.pop_front();
      n_checks++;
      if ({31'd0, retire} !== exp_v) begin
         $display("FAIL x0_retire got %b expected %h", retire, exp_v);
         n_fail++;
      end
      tick();
      // Valid but rd_wen=0: retires without writing
      set_commit(5'd3, 1'b0, 32'h0000_0055);
      rs1_addr = 5'd3;
      sb.push_back(32'h0);
      #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (rs1_data !== exp_v || wb_bp.valid !== 1'b0) begin
         $display("FAIL nowen_read got %h bp=%b expected %h bp=0", rs1_data, wb_bp.valid, exp_v);
         n_fail++;
      end
      tick();
      bus = '0;
      csr_sel = 2'd2;
      sb.push_back(32'h0);
      sb.push_back(32'h2);
      #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (rs1_data !== exp_v) begin
         $display("FAIL nowen_stored got %h expected %h", rs1_data, exp_v);
         n_fail++;
      end
      exp_v = sb.pop_front();
      n_checks++;
      if (csr_rdata !== exp_v) begin
         $display("FAIL x0_instret got %h expected %h", csr_rdata, exp_v);
         n_fail++;
      end
   endtask

   task automatic test_retire_count();
      logic [31:0] want [4];
      do_reset();
      for (int i = 0; i < 10; i++) begin
         set_commit(5'd0, 1'b0, 32'h0);
         bus.valid = (i % 2 == 0);
         tick();
      end
      bus = '0;
      want[0] = 32'd10;
      want[1] = 32'd0;
      want[2] = 32'd5;
      want[3] = 32'd0;
      for (int s = 0; s < 4; s++) sb.push_back(want[s]);
      for (int s = 0; s < 4; s++) begin
         csr_sel = 2'(s);
         #1;
         exp_v = sb.pop_front();
         n_checks++;
         if (csr_rdata !== exp_v) begin
            $display("FAIL count sel=%0d got %h expected %h", s, csr_rdata, exp_v);
            n_fail++;
         end
      end
   endtask

   task automatic check_cycle(input string name, input logic [31:0] lo, input logic [31:0] hi);
      sb.push_back(lo);
      sb.push_back(hi);
      csr_sel = 2'd0;
      #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (csr_rdata !== exp_v) begin
         $display("FAIL %s_lo got %h expected %h", name, csr_rdata, exp_v);
         n_fail++;
      end
      csr_sel = 2'd1;
      #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (csr_rdata !== exp_v) begin
         $display("FAIL %s_hi got %h expected %h", name, csr_rdata, exp_v);
         n_fail++;
      end
   endtask

   task automatic csr_write(input logic [1:0] sel, input logic [31:0] data);
      csr_we    = 1'b1;
      csr_sel   = sel;
      csr_wdata = data;
      tick();
      csr_we = 1'b0;
   endtask

   task automatic test_counter_carry();
      do_reset();
      csr_write(2'd0, 32'hFFFF_FFFE);
      tick();
      tick();
      check_cycle("carry", 32'h0, 32'h1);
      csr_write(2'd0, 32'hFFFF_FFFE);
      tick();
      // Low word is now all ones: writing high on the wrap edge must add the carry
      csr_write(2'd1, 32'h0000_0010);
      check_cycle("collide", 32'h0, 32'h11);
      bus       = '0;
      bus.valid = 1'b1;
      csr_write(2'd2, 32'h0000_0100);
      bus = '0;
      sb.push_back(32'h0000_0100);
      sb.push_back(32'h0);
      csr_sel = 2'd2;
      #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (csr_rdata !== exp_v) begin
         $display("FAIL instret_wr_lo got %h expected %h", csr_rdata, exp_v);
         n_fail++;
      end
      csr_sel = 2'd3;
      #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (csr_rdata !== exp_v) begin
         $display("FAIL instret_wr_hi got %h expected %h", csr_rdata, exp_v);
         n_fail++;
      end
      csr_write(2'd0, 32'hFFFF_FFFD);
      csr_write(2'd1, 32'hFFFF_FFFF);
      check_cycle("near_wrap", 32'hFFFF_FFFE, 32'hFFFF_FFFF);
      tick();
      tick();
      check_cycle("wrap64", 32'h0, 32'h0);
   endtask

   task automatic test_reset_during_commit();
      set_commit(5'd9, 1'b1, 32'h0000_CAFE);
      rst = 1'b0;
      tick();
      rst      = 1'b1;
      bus      = '0;
      rs1_addr = 5'd9;
      rs2_addr = 5'd5;
      sb.push_back(32'h0);
      sb.push_back(32'h0);
      #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (rs1_data !== exp_v) begin
         $display("FAIL rst_commit_x9 got %h expected %h", rs1_data, exp_v);
         n_fail++;
      end
      exp_v = sb.pop_front();
      n_checks++;
      if (rs2_data !== exp_v) begin
         $display("FAIL rst_clear_x5 got %h expected %h", rs2_data, exp_v);
         n_fail++;
      end
   endtask

`ifdef WB_TRACE_EN
   task automatic test_trace();
      set_commit(5'd5, 1'b1, 32'h5);
      bus.pc    = 32'h80;
      bus.instr = 32'h0050_0293;
      sb.push_back(32'h1);
      sb.push_back(32'h80);
      sb.push_back(32'h0050_0293);
      sb.push_back(32'h5);
      sb.push_back(32'h5);
      tick();
      bus = '0;
      exp_v = sb.pop_front();
      n_checks++;
      if ({31'd0, trace_valid} !== exp_v) begin
         $display("FAIL trace_valid got %b expected %h", trace_valid, exp_v);
         n_fail++;
      end
      exp_v = sb.pop_front();
      n_checks++;
      if (trace_pc !== exp_v) begin
         $display("FAIL trace_pc got %h expected %h", trace_pc, exp_v);
         n_fail++;
      end
      exp_v = sb.pop_front();
      n_checks++;
      if (trace_instr !== exp_v) begin
         $display("FAIL trace_instr got %h expected %h", trace_instr, exp_v);
         n_fail++;
      end
      exp_v = sb.pop_front();
      n_checks++;
      if ({27'd0, trace_rd} !== exp_v) begin
         $display("FAIL trace_rd got %h expected %h", trace_rd, exp_v);
         n_fail++;
      end
      exp_v = sb.pop_front();
      n_checks++;
      if (trace_wdata !== exp_v) begin
         $display("FAIL trace_wdata got %h expected %h", trace_wdata, exp_v);
         n_fail++;
      end
      sb.push_back(32'h0);
      tick();
      exp_v = sb.pop_front();
      n_checks++;
      if ({31'd0, trace_valid} !== exp_v) begin
         $display("FAIL trace_bubble got %b expected %h", trace_valid, exp_v);
         n_fail++;
      end
   endtask
`endif

   initial begin
      rst       = 1'b0;
      bus       = '0;
      rs1_addr  = '0;
      rs2_addr  = '0;
      csr_we    = 1'b0;
      csr_sel   = '0;
      csr_wdata = '0;
      test_reset();
      test_commit_bypass();
      test_x0();
      test_retire_count();
      test_counter_carry();
      test_commit_bypass();
      test_reset_during_commit();
`ifdef WB_TRACE_EN
      test_trace();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
